// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int FUNC_MSB     = 5;
    localparam int FUNC_LSB     = 0;
    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    // Branch displacement: sign-extended 16-bit word offset, scaled to bytes.
    function automatic logic [31:0] sext_imm16_x4(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection from the control unit's redirect decisions.
// Without FETCH_ALIGN_CHECK_EN the two low bits of the result are forced to zero.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0]           pc_plus4,
    input  logic [TARGET26_MSB:0] inst_target,
    input  logic                  jump,
    input  logic                  jump_reg,
    input  logic                  branch,
    input  logic                  alu_zero,
    input  logic [31:0]           reg_target,
    output logic [31:0]           next_pc
);

    logic [31:0] raw_next;

    always_comb begin
        raw_next = pc_plus4;
        if (jump && jump_reg) begin
            raw_next = reg_target;
        end else if (jump) begin
            raw_next = {pc_plus4[31:28], inst_target, 2'b00};
        end else if (branch && alu_zero) begin
            raw_next = pc_plus4 + sext_imm16_x4(inst_target[IMM16_MSB:IMM16_LSB]);
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign next_pc = raw_next;
`else
    assign next_pc = raw_next & ~32'h0000_0003;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over req/ready and holds it
// until accepted. Optional misaligned-target trap is enabled by FETCH_ALIGN_CHECK_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_accept,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [31:0] reg_target,
    input  logic        halted,
    output logic        fetch_fault
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg;
    logic [31:0]  inst_reg;
    logic [31:0]  next_pc;
    logic         pc_load;
    logic         inst_load;
    logic         misaligned;

    next_pc_sel u_next_pc_sel (
        .pc_plus4    (pc_plus4),
        .inst_target (inst_reg[TARGET26_MSB:TARGET26_LSB]),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .reg_target  (reg_target),
        .next_pc     (next_pc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |next_pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A halting instruction takes precedence over a faulting redirect.
    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        pc_load    = 1'b0;
        inst_load  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    inst_load  = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_accept) begin
                    if (halted || misaligned) begin
                        state_next = S_HALT;
                    end else begin
                        pc_load    = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc_reg   <= RESET_PC;
            inst_reg <= 32'h0000_0000;
        end else begin
            if (pc_load) begin
                pc_reg <= next_pc;
            end
            if (inst_load) begin
                inst_reg <= imem_rdata;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fault_reg <= 1'b0;
        end else if (state_reg == S_HOLD && inst_accept && !halted && misaligned) begin
            fault_reg <= 1'b1;
        end
    end

    assign fetch_fault = fault_reg;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign inst      = inst_reg;
    assign opcode    = inst_reg[OPCODE_MSB:OPCODE_LSB];
    assign func      = inst_reg[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a reference model predicts fetch addresses and
// held instructions; a monitor compares them whenever the DUT requests or presents output.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_accept;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        jump_reg;
    logic        branch;
    logic        alu_zero;
    logic [31:0] reg_target;
    logic        halted;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_accept (inst_accept),
        .inst        (inst),
        .opcode      (opcode),
        .func        (func),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .reg_target  (reg_target),
        .halted      (halted),
        .fetch_fault (fetch_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] addr_q[$];   // expected fetch addresses, in order
    logic [63:0] hold_q[$];   // expected {pc, inst} for each presented instruction
    logic [31:0] m_pc;        // model PC

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference next-PC rule, computed directly from the instruction semantics.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic j, input logic jr, input logic br,
                                               input logic z, input logic [31:0] rt);
        logic [31:0] p4;
        int          off;
        p4  = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (j && jr) return rt;
        if (j)       return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        if (br && z) return p4 + 32'(off);
        return p4;
    endfunction

    // Monitor: checks every new request address and every newly presented instruction.
    initial begin : monitor
        logic        req_prev;
        logic        valid_prev;
        logic [31:0] req_addr;
        logic [63:0] e;
        req_prev   = 1'b0;
        valid_prev = 1'b0;
        req_addr   = '0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (imem_req && !req_prev) begin
                    if (addr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: request at 0x%08h, none expected", imem_addr);
                    end else begin
                        chk("fetch_addr", imem_addr, addr_q.pop_front());
                    end
                    req_addr = imem_addr;
                end else if (imem_req) begin
                    chk("addr_stable", imem_addr, req_addr);
                end
                if (inst_valid && !valid_prev) begin
                    if (hold_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: inst_valid with inst 0x%08h, none expected", inst);
                    end else begin
                        e = hold_q.pop_front();
                        chk("inst", inst, e[31:0]);
                        chk("pc", pc, e[63:32]);
                        chk("opcode", {26'd0, opcode}, {26'd0, e[31:26]});
                        chk("func", {26'd0, func}, {26'd0, e[5:0]});
                        chk("pc_plus4", pc_plus4, e[63:32] + 32'd4);
                    end
                end
            end
            req_prev   = imem_req;
            valid_prev = inst_valid;
        end
    end

    task automatic drive_idle();
        inst_accept = 1'b0;
        jump        = 1'b0;
        jump_reg    = 1'b0;
        branch      = 1'b0;
        alu_zero    = 1'b0;
        halted      = 1'b0;
        reg_target  = 32'd0;
    endtask

    // One instruction: serve the fetch after wt wait cycles, then accept with the given redirect.
    task automatic txn(input logic [31:0] w, input int wt, input logic j, input logic jr,
                       input logic br, input logic z, input logic [31:0] rt, input logic h);
        int          n;
        logic [31:0] nxt;
        logic        flt;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: imem_req 0 after %0d cycles, expected 1", n);
            return;
        end
        repeat (wt) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        hold_q.push_back({m_pc, w});
        @(negedge clk);
        imem_ready = 1'b0;
        chk("valid_latency", {31'd0, inst_valid}, 32'd1);
        // Hold phase: stray ready and redirect inputs must be ignored.
        repeat ($urandom_range(0, 3)) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            jump       = 1'($urandom_range(0, 1));
            jump_reg   = 1'($urandom_range(0, 1));
            branch     = 1'($urandom_range(0, 1));
            alu_zero   = 1'($urandom_range(0, 1));
            halted     = 1'($urandom_range(0, 1));
            reg_target = $urandom;
            @(negedge clk);
        end
        imem_ready  = 1'b0;
        inst_accept = 1'b1;
        jump        = j;
        jump_reg    = jr;
        branch      = br;
        alu_zero    = z;
        reg_target  = rt;
        halted      = h;
        chk("inst_held", inst, w);
        chk("pc_held", pc, m_pc);
        nxt = model_next(m_pc, w, j, jr, br, z, rt);
        flt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        flt = !h && (nxt % 4 != 0);
`else
        nxt = nxt - (nxt % 4);
`endif
        if (!(h || flt)) begin
            addr_q.push_back(nxt);
        end
        @(negedge clk);
        drive_idle();
        if (h || flt) begin
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            chk("halt_no_valid", {31'd0, inst_valid}, 32'd0);
            chk("halt_pc", pc, m_pc);
            chk("fault_flag", {31'd0, fetch_fault}, {31'd0, flt});
        end else begin
            m_pc = nxt;
            chk("req_after_accept", {31'd0, imem_req}, 32'd1);
            chk("fault_low", {31'd0, fetch_fault}, 32'd0);
        end
    endtask

    task automatic rand_txn();
        logic [31:0] w;
        logic [31:0] rt;
        int          r;
        w  = $urandom;
        rt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
        rt = rt & ~32'h3;
`endif
        r = $urandom_range(0, 4);
        case (r)
            0:       txn(w, $urandom_range(0, 3), 1'b0, 1'b0, 1'b0, 1'b0, rt, 1'b0);
            1:       txn(w, $urandom_range(0, 3), 1'b1, 1'b0, 1'b0, 1'b0, rt, 1'b0);
            2:       txn(w, $urandom_range(0, 3), 1'b1, 1'b1, 1'b1, 1'b1, rt, 1'b0);
            3:       txn(w, $urandom_range(0, 3), 1'b0, 1'b0, 1'b1, 1'b1, rt, 1'b0);
            default: txn(w, $urandom_range(0, 3), 1'b0, 1'b1, 1'b1, 1'b0, rt, 1'b0);
        endcase
    endtask

    initial begin : stimulus
        rst_b      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        drive_idle();
        m_pc = RST_PC;
        repeat (3) @(negedge clk);

        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        addr_q.push_back(RST_PC);
        rst_b = 1'b1;
        #1;
        chk("idle_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Directed redirects
        txn(32'h0000_0000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b0);
        txn(32'h1000_FFFF, 3, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
        txn(32'h1000_FFFF, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        txn(32'h0000_0000, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 1'b0);
        txn(32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        txn(32'h0000_0000, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
        txn(32'h0000_0000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        txn(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
`ifndef FETCH_ALIGN_CHECK_EN
        txn(32'h0000_0000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            rand_txn();
        end

        // Halt: no request or valid ever again
        txn($urandom, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            inst_accept = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halted_req", {31'd0, imem_req}, 32'd0);
            chk("halted_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ready = 1'b0;
        drive_idle();

        // Reset while a request is outstanding
        rst_b = 1'b0;
        @(negedge clk);
        addr_q.delete();
        hold_q.delete();
        m_pc = RST_PC;
        addr_q.push_back(RST_PC);
        rst_b = 1'b1;
        @(negedge clk);
        chk("req_after_reset", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("req_drop_async", {31'd0, imem_req}, 32'd0);
        chk("pc_async_reset", pc, RST_PC);
        @(negedge clk);
        addr_q.push_back(RST_PC);
        rst_b = 1'b1;
        @(negedge clk);

        txn(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        txn(32'h0000_0000, 1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        txn(32'h0000_0000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 1'b0);
        repeat (10) @(negedge clk);
        chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        chk("fault_no_req", {31'd0, imem_req}, 32'd0);
`endif
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
